fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction decoder/control logic in the single-cycle MIPS core. It owns the PC and drives the instruction-memory request/hit handshake. It captures the returned word and presents it, with its PC and PC+4, to decode/datapath until the datapath retires it. It then advances sequentially or to a datapath-supplied redirect target, and parks permanently on HALT.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
(address/data width fixed at 32 bits; word-aligned fetch only)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
ihit  in  1  instruction memory hit; iload valid this cycle
iload  in  32  instruction word from memory
iREN  out  1  instruction read enable
iaddr  out  32  instruction address (= PC)
advance  in  1  datapath retires the presented instruction this cycle (its data-memory op, if any, is complete)
halt_in  in  1  decoder flags the presented instruction as HALT
redirect_valid  in  1  retiring instruction takes a branch/jump/JR
redirect_pc  in  32  target for redirect
inst  out  32  presented instruction; 32'h0 when inst_valid=0
inst_valid  out  1  inst holds a fetched, unretired instruction
inst_pc  out  32  PC of presented instruction
npc  out  32  inst_pc + 4
halted  out  1  sticky halt indication

Behaviour:
- States: IDLE, FETCH, ISSUED, HALTED. Reset state: IDLE.
- Reset (async, any state, mid-handshake included): PC=PC_INIT, inst_reg=0, inst_valid=0, halted=0, state=IDLE. Outputs during reset: iREN=0, iaddr=PC_INIT, inst=0, inst_pc=PC_INIT, npc=PC_INIT+4.
- IDLE: iREN=0. Unconditional transition to FETCH on the next edge.
- FETCH: iREN=1, iaddr=PC. While ihit=0, stay; PC is unchanged. On ihit=1, inst_reg<=iload, inst_pc<=PC, inst_valid<=1, and go to ISSUED. advance, halt_in and redirect_* are ignored in FETCH.
- ISSUED: iREN=0. inst=inst_reg, inst_valid=1. While advance=0, hold all outputs stable.
  - On advance=1 with halt_in=1: go to HALTED, halted<=1, inst_valid<=0. PC is unchanged. halt_in has priority over redirect_valid.
  - On advance=1 with halt_in=0: PC<=redirect_valid ? {redirect_pc[31:2],2'b00} : PC+4. inst_valid<=0. Go to FETCH.
- HALTED: iREN=0, inst_valid=0, halted=1. Exit only by reset. All inputs ignored.
- Arithmetic: PC+4 and npc are 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0. Redirect low two bits are forced to 0.
- Latency: minimum 2 cycles per instruction (FETCH with immediate ihit, ISSUED with immediate advance). The first iREN is asserted in the 2nd cycle after reset release.
- ihit arriving while not in FETCH is ignored. iaddr is always PC (valid as address only when iREN=1).
- halt_in and redirect_valid are sampled only on the advance edge in ISSUED.

Optional Feature:
FETCH_PERF_EN.
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on each FETCH→ISSUED transition.
  - stall_count increments on each cycle in FETCH with ihit=0, plus each cycle in ISSUED with advance=0.
  - Both saturate at 32'hFFFF_FFFF and are frozen in HALTED.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, PC_INIT=0, ihit=1 and advance=1 held: iREN=0 in cycle 1; iaddr sequence 0x0, 0x4, 0x8 in successive FETCH cycles; instruction presented every 2 cycles; npc=inst_pc+4.
- ihit delayed 3 cycles in FETCH with iload=0x2001000A: iREN held at 1 with iaddr constant; then inst=0x2001000A, inst_valid=1, inst_pc unchanged while advance=0 for 4 cycles.
- ISSUED at PC 0x40, advance=1, redirect_valid=1, redirect_pc=0x103: next iaddr=0x100. Same case with redirect_valid=0: next iaddr=0x44.
- ISSUED, advance=1, halt_in=1, redirect_valid=1: halted=1, iREN stays 0 forever, PC unchanged, later ihit/advance ignored.
- PC=0xFFFFFFFC, advance without redirect: next iaddr=0x0. Assert RST in FETCH mid-wait: outputs return to reset values immediately (asynchronously, without waiting for a clock edge); next FETCH uses PC_INIT.
- With FETCH_PERF_EN: 3 instructions, each with 2 ihit-wait cycles and 1 advance-wait cycle: fetch_count=3, stall_count=9.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/hit handshake plus the
// decode/datapath presentation and retire signals around the fetch stage.
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        advance;
    logic        halt_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] npc;
    logic        halted;

    // master = fetch unit, slave = memory/decode/datapath side
    modport master (
        input  ihit, iload, advance, halt_in, redirect_valid, redirect_pc,
        output iREN, iaddr, inst, inst_valid, inst_pc, npc, halted
    );

    modport slave (
        output ihit, iload, advance, halt_in, redirect_valid, redirect_pc,
        input  iREN, iaddr, inst, inst_valid, inst_pc, npc, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem handshake and presents one
// instruction at a time to decode. Optional perf counters under `FETCH_PERF_EN`.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | one dead cycle after reset, no request
// FETCH  | iREN high at PC, waiting for ihit
// ISSUED | instruction presented, waiting for datapath advance
// HALTED | HALT retired, parked until reset
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUED = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        iren_q;
    logic [31:0] inst_q;
    logic        inst_valid_q;
    logic [31:0] inst_pc_q;
    logic [31:0] npc_q;
    logic        halted_q;

    logic [31:0] pc_seq;
    logic [31:0] pc_redir;
    logic [31:0] pc_d;

    assign pc_seq   = pc_q + 32'd4;
    assign pc_redir = bus.redirect_pc & 32'hFFFF_FFFC;
    assign pc_d     = bus.redirect_valid ? pc_redir : pc_seq;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            pc_q         <= PC_INIT;
            iren_q       <= 1'b0;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            inst_pc_q    <= PC_INIT;
            npc_q        <= PC_INIT + 32'd4;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    iren_q  <= 1'b1;
                end
                FETCH: begin
                    if (bus.ihit) begin
                        state_q      <= ISSUED;
                        iren_q       <= 1'b0;
                        inst_q       <= bus.iload;
                        inst_valid_q <= 1'b1;
                        inst_pc_q    <= pc_q;
                        npc_q        <= pc_seq;
                    end
                end
                ISSUED: begin
                    if (bus.advance) begin
                        inst_q       <= 32'h0;
                        inst_valid_q <= 1'b0;
                        // HALT wins over any redirect on the same retire
                        if (bus.halt_in) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            iren_q  <= 1'b1;
                            pc_q    <= pc_d;
                        end
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= IDLE;
                    iren_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.iREN       = iren_q;
    assign bus.iaddr      = pc_q;
    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.npc        = npc_q;
    assign bus.halted     = halted_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        fetch_evt;
    logic        stall_evt;

    assign fetch_evt = (state_q == FETCH) && bus.ihit;
    assign stall_evt = ((state_q == FETCH) && !bus.ihit) ||
                       ((state_q == ISSUED) && !bus.advance);

    // counters saturate rather than wrap; HALTED produces no events
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (fetch_evt && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of fetched words checked when
// presented, plus a PC model for sequential/redirect/wrap/halt/reset cases.
module tb_fetch_unit;
    logic CLK;
    logic RST;

    fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] npc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk;
    int          n_pass;
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Called at a negedge with the DUT in FETCH at exp_pc.
    task automatic run_instr(input int hit_wait, input int adv_wait,
                             input logic redir, input logic [31:0] rpc,
                             input logic halt, input logic [31:0] word);
        exp_t e;
        chk("iren_fetch", {31'b0, bus.iREN}, 32'd1);
        chk("iaddr", bus.iaddr, exp_pc);
        bus.ihit  = 1'b0;
        bus.iload = 32'hDEAD_BEEF;
        for (int i = 0; i < hit_wait; i++) begin
            cyc();
            chk("iren_wait", {31'b0, bus.iREN}, 32'd1);
            chk("iaddr_wait", bus.iaddr, exp_pc);
        end
        bus.ihit  = 1'b1;
        bus.iload = word;
        sb_q.push_back('{word: word, pc: exp_pc, npc: exp_pc + 32'd4});
        cyc();
        bus.ihit  = 1'b0;
        bus.iload = 32'h0;
        chk("inst_valid", {31'b0, bus.inst_valid}, 32'd1);
        chk("iren_issued", {31'b0, bus.iREN}, 32'd0);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("inst", bus.inst, e.word);
            chk("inst_pc", bus.inst_pc, e.pc);
            chk("npc", bus.npc, e.npc);
        end
        for (int i = 0; i < adv_wait; i++) begin
            bus.advance = 1'b0;
            bus.halt_in = 1'b1;
            cyc();
            chk("hold_inst", bus.inst, word);
            chk("hold_valid", {31'b0, bus.inst_valid}, 32'd1);
            chk("hold_pc", bus.inst_pc, e.pc);
        end
        bus.advance        = 1'b1;
        bus.halt_in        = halt;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        cyc();
        bus.advance        = 1'b0;
        bus.halt_in        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        chk("retired_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("retired_inst", bus.inst, 32'h0);
        if (halt) begin
            chk("halted", {31'b0, bus.halted}, 32'd1);
            chk("iren_halt", {31'b0, bus.iREN}, 32'd0);
            chk("pc_halt", bus.iaddr, exp_pc);
        end else begin
            exp_pc = redir ? {rpc[31:2], 2'b00} : exp_pc + 32'd4;
            chk("not_halted", {31'b0, bus.halted}, 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_iren"}, {31'b0, bus.iREN}, 32'd0);
        chk({tag, "_iaddr"}, bus.iaddr, 32'h0);
        chk({tag, "_inst"}, bus.inst, 32'h0);
        chk({tag, "_valid"}, {31'b0, bus.inst_valid}, 32'd0);
        chk({tag, "_inst_pc"}, bus.inst_pc, 32'h0);
        chk({tag, "_npc"}, bus.npc, 32'h4);
        chk({tag, "_halted"}, {31'b0, bus.halted}, 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        exp_pc = 32'h0;
        RST                = 1'b1;
        bus.ihit           = 1'b0;
        bus.iload          = 32'h0;
        bus.advance        = 1'b0;
        bus.halt_in        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_reset_vals("rst");
        RST = 1'b0;
        chk("idle_iren", {31'b0, bus.iREN}, 32'd0);
        cyc();

        // back-to-back fetches at 0, 4, 8
        run_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h1111_0000);
        run_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h1111_0004);
        run_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h1111_0008);
        chk("seq_pc", exp_pc, 32'h0000_000C);
        // delayed hit, held presentation
        run_instr(3, 4, 1'b0, 32'h0, 1'b0, 32'h2001_000A);
        // redirects
        run_instr(1, 0, 1'b1, 32'h0000_0040, 1'b0, 32'h0800_0010);
        run_instr(0, 1, 1'b1, 32'h0000_0103, 1'b0, 32'h0800_0040);
        chk("redir_pc", bus.iaddr, 32'h0000_0100);
        run_instr(0, 0, 1'b1, 32'h0000_0040, 1'b0, 32'h0800_0100);
        run_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h0000_0020);
        chk("seq_after_40", bus.iaddr, 32'h0000_0044);
        // wrap from the top of the address space
        run_instr(0, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0800_0000);
        run_instr(2, 0, 1'b0, 32'h0, 1'b0, 32'hAAAA_5555);
        chk("wrap_pc", bus.iaddr, 32'h0);
        run_instr(0, 0, 1'b1, 32'h0000_0200, 1'b0, 32'h0800_0080);
        run_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h3C01_1234);

        // async reset while waiting for ihit at 0x204
        chk("pre_rst_iaddr", bus.iaddr, 32'h0000_0204);
        bus.ihit = 1'b0;
        cyc();
        cyc();
        #2 RST = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge CLK);
        RST = 1'b0;
        exp_pc = 32'h0;
        chk("idle2_iren", {31'b0, bus.iREN}, 32'd0);
        cyc();

        run_instr(2, 1, 1'b0, 32'h0, 1'b0, 32'h0123_4567);
        run_instr(2, 1, 1'b0, 32'h0, 1'b0, 32'h89AB_CDEF);
        run_instr(2, 1, 1'b0, 32'h0, 1'b0, 32'h0F0F_F0F0);
`ifdef FETCH_PERF_EN
        chk("fetch_count", fetch_count, 32'd3);
        chk("stall_count", stall_count, 32'd9);
`endif

        // halt with a competing redirect; nothing afterwards may restart fetch
        run_instr(1, 2, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_000C);
        for (int i = 0; i < 6; i++) begin
            bus.ihit           = 1'b1;
            bus.iload          = 32'h5A5A_5A5A;
            bus.advance        = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 32'h0000_0800;
            cyc();
            chk("halt_iren", {31'b0, bus.iREN}, 32'd0);
            chk("halt_pc", bus.iaddr, 32'h0000_000C);
            chk("halt_flag", {31'b0, bus.halted}, 32'd1);
            chk("halt_valid", {31'b0, bus.inst_valid}, 32'd0);
        end
`ifdef FETCH_PERF_EN
        chk("fetch_frozen", fetch_count, 32'd4);
        chk("stall_frozen", stall_count, 32'd12);
`endif
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
